icache_refill_ctrl: RTL and testbench

- Parametrised instruction-cache line refill controller that replaces the single-word miss path between the fetch stage and the IRAM controller.
- On a fetch miss it fetches a whole line of WORDS_PER_LINE words, critical word first with wrap-around.
- It forwards the missed word to fetch as soon as it arrives, and delivers the assembled line to the cache array in one write cycle.
- It adds flush (redirect) handling and a per-word timeout, which the single-word path lacks.

---
 rtl/icache_refill_ctrl.sv | 169 ++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache line refill controller.
// Fetches a full line critical-word-first with wrap-around, forwards the
// missed word to fetch as soon as it arrives, and writes the assembled line
// to the cache array in a single cycle. Handles fetch redirects (flush) and
// aborts a refill when a single word takes too long to arrive.
module icache_refill_ctrl #(
  parameter int unsigned PC_SIZE        = 32,
  parameter int unsigned WORD_SIZE      = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  logic                                miss_req,
  input  logic [PC_SIZE-1:0]                  miss_addr,
  input  logic                                flush,
  input  logic [WORD_SIZE-1:0]                mem_word,
  input  logic                                word_ready,
  output logic [PC_SIZE-1:0]                  ram_address,
  output logic                                miss_cache,
  output logic                                crit_valid,
  output logic [WORD_SIZE-1:0]                crit_word,
  output logic                                line_wr_en,
  output logic [PC_SIZE-1:0]                  line_wr_addr,
  output logic [WORD_SIZE*WORDS_PER_LINE-1:0] line_wr_data,
  output logic                                busy,
  output logic                                timeout_err
);

  localparam int unsigned WORD_BYTES = WORD_SIZE / 8;
  localparam int unsigned OB         = $clog2(WORDS_PER_LINE);
  localparam int unsigned LB         = $clog2(WORD_BYTES);
  localparam int unsigned CNT_W      = OB + 1;
  localparam int unsigned WAIT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LINE_W     = WORD_SIZE * WORDS_PER_LINE;

  // Clears the word-offset and byte-offset bits to get the line base.
  localparam logic [PC_SIZE-1:0] LINE_MASK =
    ~((PC_SIZE'(1) << (OB + LB)) - PC_SIZE'(1));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t              state;
  logic [PC_SIZE-1:0]  base;
  logic [OB-1:0]       offset;
  logic [CNT_W-1:0]    count;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                drop;
  logic [LINE_W-1:0]   slots;

  logic [LINE_W-1:0]   slots_merged;
  logic [OB-1:0]       offset_next;
  logic [OB-1:0]       start_off;
  logic [PC_SIZE-1:0]  start_base;
  logic [PC_SIZE-1:0]  addr_next;
  logic                last_word;
  logic                timeout_hit;

  // Line storage with the incoming word dropped into its slot, plus address helpers.
  always_comb begin
    slots_merged = slots;
    for (int i = 0; i < int'(WORDS_PER_LINE); i++) begin
      if (OB'(i) == offset) begin
        slots_merged[i*WORD_SIZE +: WORD_SIZE] = mem_word;
      end
    end
    offset_next = offset + OB'(1);
    start_off   = miss_addr[LB +: OB];
    start_base  = miss_addr & LINE_MASK;
    addr_next   = base | (PC_SIZE'(offset_next) << LB);
    last_word   = (count == CNT_W'(WORDS_PER_LINE - 1));
    timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES));
  end

  // Refill FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state        <= IDLE;
      base         <= '0;
      offset       <= '0;
      count        <= '0;
      wait_cnt     <= '0;
      drop         <= 1'b0;
      slots        <= '0;
      ram_address  <= '0;
      miss_cache   <= 1'b0;
      crit_valid   <= 1'b0;
      crit_word    <= '0;
      line_wr_en   <= 1'b0;
      line_wr_addr <= '0;
      line_wr_data <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      // Single-cycle strobes fall back to zero unless re-asserted below.
      crit_valid <= 1'b0;
      line_wr_en <= 1'b0;

      case (state)
        IDLE: begin
          // A miss coinciding with a redirect is stale and not taken.
          if (miss_req && !flush) begin
            base        <= start_base;
            offset      <= start_off;
            count       <= '0;
            wait_cnt    <= '0;
            drop        <= 1'b0;
            timeout_err <= 1'b0;
            ram_address <= start_base | (PC_SIZE'(start_off) << LB);
            miss_cache  <= 1'b1;
            busy        <= 1'b1;
            state       <= REQ;
          end
        end

        REQ: begin
          // A redirect only cancels forwarding; the line is still filled.
          drop <= drop | flush;
          if (word_ready) begin
            slots    <= slots_merged;
            offset   <= offset_next;
            count    <= count + CNT_W'(1);
            wait_cnt <= '0;
            if ((count == '0) && !drop && !flush) begin
              crit_valid <= 1'b1;
              crit_word  <= mem_word;
            end
            if (last_word) begin
              miss_cache   <= 1'b0;
              line_wr_en   <= 1'b1;
              line_wr_addr <= base;
              line_wr_data <= slots_merged;
              state        <= WRITE;
            end else begin
              ram_address <= addr_next;
            end
          end else if (timeout_hit) begin
            miss_cache  <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ABORT;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        WRITE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        ABORT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: a 4-word-line instance with an
// 8-cycle timeout and an 8-word-line instance, both driven from shared stimulus.
module tb_icache_refill_ctrl;

  logic         clk = 1'b0;
  logic         nrst;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         flush;
  logic [31:0]  mem_word;
  logic         word_ready;

  logic [31:0]  ram_address, crit_word, line_wr_addr;
  logic         miss_cache, crit_valid, line_wr_en, busy, timeout_err;
  logic [127:0] line_wr_data;

  logic [31:0]  ram_address8, crit_word8, line_wr_addr8;
  logic         miss_cache8, crit_valid8, line_wr_en8, busy8, timeout_err8;
  logic [255:0] line_wr_data8;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  icache_refill_ctrl #(
    .PC_SIZE(32), .WORD_SIZE(32), .WORDS_PER_LINE(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .nrst(nrst), .miss_req(miss_req), .miss_addr(miss_addr),
    .flush(flush), .mem_word(mem_word), .word_ready(word_ready),
    .ram_address(ram_address), .miss_cache(miss_cache), .crit_valid(crit_valid),
    .crit_word(crit_word), .line_wr_en(line_wr_en), .line_wr_addr(line_wr_addr),
    .line_wr_data(line_wr_data), .busy(busy), .timeout_err(timeout_err)
  );

  icache_refill_ctrl #(
    .PC_SIZE(32), .WORD_SIZE(32), .WORDS_PER_LINE(8), .TIMEOUT_CYCLES(255)
  ) dut8 (
    .clk(clk), .nrst(nrst), .miss_req(miss_req), .miss_addr(miss_addr),
    .flush(flush), .mem_word(mem_word), .word_ready(word_ready),
    .ram_address(ram_address8), .miss_cache(miss_cache8), .crit_valid(crit_valid8),
    .crit_word(crit_word8), .line_wr_en(line_wr_en8), .line_wr_addr(line_wr_addr8),
    .line_wr_data(line_wr_data8), .busy(busy8), .timeout_err(timeout_err8)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nrst = 1'b0; miss_req = 1'b0; miss_addr = '0; flush = 1'b0;
    mem_word = '0; word_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_ram_address", 256'(ram_address), 256'(0));
    chk("rst_miss_cache",  256'(miss_cache),  256'(0));
    chk("rst_crit_valid",  256'(crit_valid),  256'(0));
    chk("rst_line_wr_en",  256'(line_wr_en),  256'(0));
    chk("rst_busy",        256'(busy),        256'(0));
    chk("rst_timeout_err", 256'(timeout_err), 256'(0));

    // Defaults: miss at 0x1008, word_ready always high
    nrst = 1'b1; miss_req = 1'b1; miss_addr = 32'h1008; word_ready = 1'b1; mem_word = 32'hA0;
    tick();
    miss_req = 1'b0;
    chk("def_accept_busy",  256'(busy),        256'(1));
    chk("def_accept_mc",    256'(miss_cache),  256'(1));
    chk("def_addr0",        256'(ram_address), 256'(32'h1008));
    chk("def_no_crit_yet",  256'(crit_valid),  256'(0));
    tick();
    chk("def_crit_valid",   256'(crit_valid),  256'(1));
    chk("def_crit_word",    256'(crit_word),   256'(32'hA0));
    chk("def_addr1",        256'(ram_address), 256'(32'h100C));
    mem_word = 32'hA1;
    tick();
    chk("def_crit_one_cyc", 256'(crit_valid),  256'(0));
    chk("def_addr2",        256'(ram_address), 256'(32'h1000));
    mem_word = 32'hA2;
    tick();
    chk("def_addr3",        256'(ram_address), 256'(32'h1004));
    chk("def_no_wr_early",  256'(line_wr_en),  256'(0));
    mem_word = 32'hA3;
    tick();
    word_ready = 1'b0;
    chk("def_wr_en",        256'(line_wr_en),   256'(1));
    chk("def_wr_addr",      256'(line_wr_addr), 256'(32'h1000));
    chk("def_wr_data",      256'(line_wr_data), 256'({32'hA1, 32'hA0, 32'hA3, 32'hA2}));
    chk("def_mc_drop",      256'(miss_cache),   256'(0));
    chk("def_busy_write",   256'(busy),         256'(1));
    tick();
    chk("def_wr_one_cyc",   256'(line_wr_en),   256'(0));
    chk("def_busy_low",     256'(busy),         256'(0));
    chk("def_wr_addr_hold", 256'(line_wr_addr), 256'(32'h1000));

    // Aligned miss with word_ready every third cycle
    miss_req = 1'b1; miss_addr = 32'h2000; word_ready = 1'b0;
    tick();
    miss_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      word_ready = 1'b0;
      repeat (2) begin
        tick();
        chk("stall_addr_hold", 256'(ram_address), 256'(32'h2000 + 32'(4 * i)));
        chk("stall_mc_high",   256'(miss_cache),  256'(1));
      end
      word_ready = 1'b1; mem_word = 32'hB0 + 32'(i);
      tick();
      if (i == 0) chk("stall_crit_word", 256'(crit_word), 256'(32'hB0));
      if (i < 3) chk("stall_addr_adv", 256'(ram_address), 256'(32'h2000 + 32'(4 * (i + 1))));
    end
    word_ready = 1'b0;
    chk("stall_wr_en",   256'(line_wr_en),   256'(1));
    chk("stall_wr_addr", 256'(line_wr_addr), 256'(32'h2000));
    chk("stall_wr_data", 256'(line_wr_data), 256'({32'hB3, 32'hB2, 32'hB1, 32'hB0}));
    tick();
    chk("stall_busy_low", 256'(busy), 256'(0));

    // Flush before the first word: critical word suppressed, line still written
    miss_req = 1'b1; miss_addr = 32'h1004;
    tick();
    miss_req = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      word_ready = 1'b1; mem_word = 32'hC0 + 32'(i);
      tick();
      chk("flush_no_crit", 256'(crit_valid), 256'(0));
    end
    word_ready = 1'b0;
    chk("flush_wr_en",   256'(line_wr_en),   256'(1));
    chk("flush_wr_addr", 256'(line_wr_addr), 256'(32'h1000));
    chk("flush_wr_data", 256'(line_wr_data), 256'({32'hC2, 32'hC1, 32'hC0, 32'hC3}));
    tick();

    // Flush together with miss_req in IDLE: miss not taken
    miss_req = 1'b1; flush = 1'b1; miss_addr = 32'h4000;
    tick();
    miss_req = 1'b0; flush = 1'b0;
    chk("flushmiss_busy", 256'(busy),       256'(0));
    chk("flushmiss_mc",   256'(miss_cache), 256'(0));

    // Timeout: word_ready held low
    miss_req = 1'b1; miss_addr = 32'h3000;
    tick();
    miss_req = 1'b0;
    repeat (8) tick();
    chk("to_mc_still_high", 256'(miss_cache), 256'(1));
    chk("to_no_err_yet",    256'(timeout_err), 256'(0));
    tick();
    chk("to_mc_drop",  256'(miss_cache),  256'(0));
    chk("to_err_set",  256'(timeout_err), 256'(1));
    chk("to_no_wr",    256'(line_wr_en),  256'(0));
    tick();
    chk("to_busy_low", 256'(busy),        256'(0));
    chk("to_err_stky", 256'(timeout_err), 256'(1));
    chk("to_no_wr2",   256'(line_wr_en),  256'(0));
    miss_req = 1'b1; miss_addr = 32'h3000;
    tick();
    miss_req = 1'b0;
    chk("to_err_clr",  256'(timeout_err), 256'(0));
    chk("to_new_busy", 256'(busy),        256'(1));

    // Reset after 2 of 4 words
    word_ready = 1'b1; mem_word = 32'hD0;
    tick();
    mem_word = 32'hD1;
    tick();
    nrst = 1'b0; word_ready = 1'b0;
    tick();
    chk("mrst_ram",     256'(ram_address),  256'(0));
    chk("mrst_mc",      256'(miss_cache),   256'(0));
    chk("mrst_cv",      256'(crit_valid),   256'(0));
    chk("mrst_cw",      256'(crit_word),    256'(0));
    chk("mrst_wr_en",   256'(line_wr_en),   256'(0));
    chk("mrst_wr_addr", 256'(line_wr_addr), 256'(0));
    chk("mrst_wr_data", 256'(line_wr_data), 256'(0));
    chk("mrst_busy",    256'(busy),         256'(0));
    chk("mrst_err",     256'(timeout_err),  256'(0));
    nrst = 1'b1;
    tick(); tick();
    chk("mrst_no_wr", 256'(line_wr_en), 256'(0));
    miss_req = 1'b1; miss_addr = 32'h3004;
    tick();
    miss_req = 1'b0;
    chk("mrst_refill_addr", 256'(ram_address), 256'(32'h3004));
    for (int i = 0; i < 4; i++) begin
      word_ready = 1'b1; mem_word = 32'hE0 + 32'(i);
      tick();
    end
    word_ready = 1'b0;
    chk("mrst_refill_wr",   256'(line_wr_en),   256'(1));
    chk("mrst_refill_data", 256'(line_wr_data), 256'({32'hE2, 32'hE1, 32'hE0, 32'hE3}));
    tick();

    // Eight-word line: re-align both instances, then miss at 0x101C
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
    miss_req = 1'b1; miss_addr = 32'h101C;
    tick();
    miss_req = 1'b0;
    chk("w8_addr0", 256'(ram_address8), 256'(32'h101C));
    for (int i = 0; i < 8; i++) begin
      word_ready = 1'b1; mem_word = 32'hF0 + 32'(i);
      tick();
      if (i == 0) chk("w8_crit_word", 256'(crit_word8), 256'(32'hF0));
      if (i < 7) chk("w8_addr", 256'(ram_address8), 256'(32'h1000 + 32'(4 * i)));
    end
    word_ready = 1'b0;
    chk("w8_wr_en",   256'(line_wr_en8),   256'(1));
    chk("w8_wr_addr", 256'(line_wr_addr8), 256'(32'h1000));
    chk("w8_wr_data", 256'(line_wr_data8),
        256'({32'hF0, 32'hF7, 32'hF6, 32'hF5, 32'hF4, 32'hF3, 32'hF2, 32'hF1}));
    tick();
    chk("w8_busy_low", 256'(busy8), 256'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
